io_router: RTL and testbench

Memory-mapped I/O router between the AVR core's data port and the board peripherals: bank register, VGA border, PS/2 keyboard, SD-card SPI controller. Successor of the single-latch port decoder at 0x20–0x24. The window base address is now a parameter. The one-byte keyboard latch is replaced by a parametrised scancode FIFO with overflow tracking. An interrupt-request output signals a non-empty keyboard buffer. Sits between `core`, `memory` and the peripheral units in the board top level.

---
 rtl/io_router_pkg.sv | 34 +++
 rtl/kb_fifo.sv | 70 +++++++
 rtl/io_router.sv | 152 +++++++++++++++
 tb/tb_io_router.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : io_router_pkg
//  Purpose  : Register offsets, status bit positions and command-write bit
//             positions shared by the I/O router and its keyboard FIFO.
//  Revision : 1.0  initial release
// ============================================================================
package io_router_pkg;

  // Register offsets inside the 8-byte window
  localparam logic [2:0] REG_BANK     = 3'd0;
  localparam logic [2:0] REG_KB       = 3'd1;
  localparam logic [2:0] REG_STAT     = 3'd2;
  localparam logic [2:0] REG_SPI_DATA = 3'd3;
  localparam logic [2:0] REG_SPI_CMD  = 3'd4;
  localparam logic [2:0] REG_IE       = 3'd5;

  // Status register bit positions
  localparam int ST_NE   = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_TMO  = 2;
  localparam int ST_FULL = 3;
  localparam int ST_OVF  = 4;

  // Command-write bit positions
  localparam int CMD_POP      = 0;  // status write: pop one scancode
  localparam int CMD_CLR_OVF  = 7;  // status write: clear overflow flag
  localparam int CMD_SPI_SENT = 7;  // SPI command write: latch level

  // Mask that strips the offset bits from an address
  localparam logic [15:0] WIN_MASK = 16'hFFF8;

endpackage
`default_nettype wire

// File: rtl/kb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : kb_fifo
//  Purpose  : Register-array scancode FIFO. Push on a full FIFO drops the
//             byte and pulses overflow, unless a pop happens the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module kb_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));

  // A pop frees a slot in the same cycle, so push into a full FIFO succeeds
  // when paired with a pop; a push into an empty FIFO never pairs with a pop.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign overflow  = push & full & ~w_do_pop;

  // Head is forced to zero when nothing is stored
  assign rdata = empty ? 8'h00 : r_mem[r_rd_ptr];

  // Storage array, written at the tail; contents need no reset
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_router.sv
`default_nettype none
// ============================================================================
//  Module   : io_router
//  Purpose  : Memory-mapped I/O router: decodes an 8-byte window at BASE for
//             bank, border, keyboard FIFO, SPI and interrupt-enable
//             registers; passes RAM data through outside the window.
//  Revision : 1.0  initial release
// ============================================================================
module io_router
  import io_router_pkg::*;
#(
  parameter logic [15:0] BASE     = 16'h0020,
  parameter int          KB_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  cpu_dout,
  input  logic        we,
  input  logic [7:0]  mem_din,
  output logic [7:0]  din,
  input  logic        ps2_hit,
  input  logic [7:0]  ps2_data,
  input  logic [1:0]  spi_st,
  input  logic [7:0]  spi_din,
  output logic [7:0]  bank,
  output logic [2:0]  border,
  output logic [7:0]  spi_out,
  output logic [1:0]  spi_cmd,
  output logic        spi_sent,
  output logic        irq
);

  logic [7:0] r_bank;
  logic [2:0] r_border;
  logic [7:0] r_spi_out;
  logic [1:0] r_spi_cmd;
  logic       r_spi_sent;
  logic       r_ie;
  logic       r_ovf;
  logic       r_irq;

  logic       w_sel;
  logic [2:0] w_off;
  logic       w_wr;
  logic       w_pop;
  logic       w_clr_ovf;
  logic [7:0] w_kb_head;
  logic       w_kb_empty;
  logic       w_kb_full;
  logic       w_kb_overflow;
  logic [7:0] w_status;

  assign w_sel     = (address & WIN_MASK) == (BASE & WIN_MASK);
  assign w_off     = address[2:0];
  assign w_wr      = we & w_sel;
  assign w_pop     = w_wr && (w_off == REG_STAT) && cpu_dout[CMD_POP];
  assign w_clr_ovf = w_wr && (w_off == REG_STAT) && cpu_dout[CMD_CLR_OVF];

  kb_fifo #(
    .DEPTH (KB_DEPTH)
  ) u_kb_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (ps2_hit),
    .pop      (w_pop),
    .wdata    (ps2_data),
    .rdata    (w_kb_head),
    .empty    (w_kb_empty),
    .full     (w_kb_full),
    .overflow (w_kb_overflow)
  );

  // Status byte assembly
  always_comb begin
    w_status          = 8'h00;
    w_status[ST_NE]   = ~w_kb_empty;
    w_status[ST_BUSY] = spi_st[0];
    w_status[ST_TMO]  = spi_st[1];
    w_status[ST_FULL] = w_kb_full;
    w_status[ST_OVF]  = r_ovf;
  end

  // Read-data multiplexer; reads never change state
  always_comb begin
    din = mem_din;
    if (w_sel) begin
      case (w_off)
        REG_BANK:     din = r_bank;
        REG_KB:       din = w_kb_head;
        REG_STAT:     din = w_status;
        REG_SPI_DATA: din = spi_din;
        REG_SPI_CMD:  din = {r_spi_sent, 5'b0, r_spi_cmd};
        REG_IE:       din = {7'b0, r_ie};
        default:      din = 8'h00;
      endcase
    end
  end

  // Software-writable peripheral registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bank     <= 8'h00;
      r_border   <= 3'b000;
      r_spi_out  <= 8'h00;
      r_spi_cmd  <= 2'b00;
      r_spi_sent <= 1'b0;
      r_ie       <= 1'b0;
    end else if (w_wr) begin
      case (w_off)
        REG_BANK:     r_bank    <= cpu_dout;
        REG_KB:       r_border  <= cpu_dout[2:0];
        REG_SPI_DATA: r_spi_out <= cpu_dout;
        REG_SPI_CMD: begin
          r_spi_sent <= cpu_dout[CMD_SPI_SENT];
          r_spi_cmd  <= cpu_dout[1:0];
        end
        REG_IE:       r_ie      <= cpu_dout[0];
        default:      ;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_kb_overflow) begin
      r_ovf <= 1'b1;
    end else if (w_clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  // Registered interrupt request from enabled, non-empty keyboard buffer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_ie & ~w_kb_empty;
    end
  end

  assign bank     = r_bank;
  assign border   = r_border;
  assign spi_out  = r_spi_out;
  assign spi_cmd  = r_spi_cmd;
  assign spi_sent = r_spi_sent;
  assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_io_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_router
//  Purpose  : Self-checking bench for io_router with a scancode scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_io_router;

  localparam logic [15:0] BASE     = 16'h0020;
  localparam int          KB_DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        we = 1'b0;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  din;
  logic        ps2_hit = 1'b0;
  logic [7:0]  ps2_data = 8'h00;
  logic [1:0]  spi_st = 2'b00;
  logic [7:0]  spi_din = 8'h00;
  logic [7:0]  bank;
  logic [2:0]  border;
  logic [7:0]  spi_out;
  logic [1:0]  spi_cmd;
  logic        spi_sent;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_fifo [$];   // scancode scoreboard
  logic [7:0] exp_q  [$];   // pending read expectations
  bit         m_ovf = 1'b0;

  io_router #(
    .BASE     (BASE),
    .KB_DEPTH (KB_DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .cpu_dout (cpu_dout),
    .we       (we),
    .mem_din  (mem_din),
    .din      (din),
    .ps2_hit  (ps2_hit),
    .ps2_data (ps2_data),
    .spi_st   (spi_st),
    .spi_din  (spi_din),
    .bank     (bank),
    .border   (border),
    .spi_out  (spi_out),
    .spi_cmd  (spi_cmd),
    .spi_sent (spi_sent),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    return {3'b000, m_ovf, (m_fifo.size() == KB_DEPTH), spi_st[1], spi_st[0],
            (m_fifo.size() != 0)};
  endfunction

  function automatic logic [7:0] exp_head();
    return (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
  endfunction

  // Combinational read: expectation queued, then compared against din
  task automatic read_reg(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    exp_q.push_back(exp);
    address = addr;
    #1;
    check_val(tag, din, exp_q.pop_front());
  endtask

  // One clock of stimulus: optional scancode strobe and optional CPU write
  task automatic step(input bit do_push, input logic [7:0] pd,
                      input bit do_wr, input logic [15:0] waddr, input logic [7:0] wd);
    int  pre;
    bit  pop_req, clr_req, ovf_set;
    pre     = m_fifo.size();
    pop_req = do_wr && (waddr == BASE + 16'd2) && wd[0] && (pre != 0);
    clr_req = do_wr && (waddr == BASE + 16'd2) && wd[7];
    ovf_set = 1'b0;
    if (pop_req) void'(m_fifo.pop_front());
    if (do_push) begin
      if (pre < KB_DEPTH || pop_req) m_fifo.push_back(pd);
      else ovf_set = 1'b1;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (clr_req) m_ovf = 1'b0;

    ps2_hit  = do_push;
    ps2_data = pd;
    we       = do_wr;
    address  = waddr;
    cpu_dout = wd;
    @(posedge clock);
    #1;
    ps2_hit = 1'b0;
    we      = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] d);
    step(1'b0, 8'h00, 1'b1, addr, d);
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b1, d, 1'b0, 16'h0000, 8'h00);
  endtask

  initial begin
    logic [7:0] reset_exp [8];
    mem_din = 8'hA5;
    spi_din = 8'h6E;
    repeat (2) @(posedge clock);
    #1;
    // Outputs held at reset values while reset is asserted
    check_val("rst_bank", bank, 8'h00);
    check_val("rst_misc", {border, spi_cmd, spi_sent, irq, 1'b0}, 8'h00);
    check_val("rst_spi_out", spi_out, 8'h00);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Window contents after reset, and RAM pass-through outside it
    reset_exp = '{8'h00, 8'h00, 8'h00, 8'h6E, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      read_reg($sformatf("rst_rd+%0d", i), BASE + 16'(i), reset_exp[i]);
    end
    read_reg("ram_pass", 16'h0100, 8'hA5);
    read_reg("ram_below", BASE - 16'd1, 8'hA5);
    read_reg("ram_above", BASE + 16'd8, 8'hA5);

    // Bank and border
    wr(BASE + 16'd0, 8'h37);
    wr(BASE + 16'd1, 8'hFF);
    check_val("bank", bank, 8'h37);
    check_val("border", {5'b0, border}, 8'h07);
    read_reg("bank_rd", BASE, 8'h37);
    wr(BASE + 16'd8, 8'h99);   // outside window, no effect
    check_val("bank_outside", bank, 8'h37);
    wr(BASE + 16'd6, 8'hFF);
    read_reg("rd+6", BASE + 16'd6, 8'h00);
    read_reg("rd+7", BASE + 16'd7, 8'h00);

    // Basic FIFO order
    push(8'h1C); push(8'h32); push(8'hF0);
    read_reg("head", BASE + 16'd1, exp_head());
    read_reg("stat", BASE + 16'd2, exp_status());
    for (int i = 0; i < 3; i++) begin
      wr(BASE + 16'd2, 8'h01);
      read_reg("head_pop", BASE + 16'd1, exp_head());
      read_reg("stat_pop", BASE + 16'd2, exp_status());
    end
    wr(BASE + 16'd2, 8'h01);   // pop when empty is ignored
    read_reg("stat_empty_pop", BASE + 16'd2, 8'h00);

    // Simultaneous push and pop on an empty FIFO: only the push lands
    step(1'b1, 8'h44, 1'b1, BASE + 16'd2, 8'h01);
    read_reg("head_pp_empty", BASE + 16'd1, exp_head());
    read_reg("stat_pp_empty", BASE + 16'd2, exp_status());
    wr(BASE + 16'd2, 8'h01);

    // Overflow
    for (int i = 0; i <= KB_DEPTH; i++) push(8'h10 + 8'(i));
    read_reg("stat_ovf", BASE + 16'd2, 8'h19);
    read_reg("stat_ovf_m", BASE + 16'd2, exp_status());
    wr(BASE + 16'd2, 8'h80);
    read_reg("stat_clr", BASE + 16'd2, 8'h09);
    read_reg("head_clr", BASE + 16'd1, exp_head());
    // Push + pop while full: count unchanged, no overflow
    step(1'b1, 8'hC3, 1'b1, BASE + 16'd2, 8'h01);
    read_reg("stat_pp_full", BASE + 16'd2, 8'h09);
    read_reg("head_pp_full", BASE + 16'd1, exp_head());
    // Overflow set and clear in the same cycle: set wins
    step(1'b1, 8'hEE, 1'b1, BASE + 16'd2, 8'h80);
    read_reg("stat_set_wins", BASE + 16'd2, exp_status());
    wr(BASE + 16'd2, 8'h80);
    // Drain and verify every entry
    for (int i = 0; i < KB_DEPTH; i++) begin
      read_reg("drain", BASE + 16'd1, exp_head());
      wr(BASE + 16'd2, 8'h01);
    end
    read_reg("stat_drained", BASE + 16'd2, exp_status());

    // SPI registers
    wr(BASE + 16'd4, 8'h83);
    check_val("spi_cmd", {5'b0, spi_sent, spi_cmd}, 8'h07);
    read_reg("spi_cmd_rd", BASE + 16'd4, 8'h83);
    wr(BASE + 16'd3, 8'h5C);
    check_val("spi_out", spi_out, 8'h5C);
    spi_st = 2'b11;
    read_reg("stat_spi", BASE + 16'd2, exp_status());
    spi_st = 2'b00;
    wr(BASE + 16'd4, 8'h01);
    check_val("spi_sent_clr", {5'b0, spi_sent, spi_cmd}, 8'h01);

    // Interrupt timing
    wr(BASE + 16'd5, 8'h01);
    read_reg("ie_rd", BASE + 16'd5, 8'h01);
    push(8'h5A);
    check_val("irq_edge1", {7'b0, irq}, 8'h00);
    @(posedge clock); #1;
    check_val("irq_edge2", {7'b0, irq}, 8'h01);
    wr(BASE + 16'd2, 8'h01);
    check_val("irq_pop_edge1", {7'b0, irq}, 8'h01);
    @(posedge clock); #1;
    check_val("irq_pop_edge2", {7'b0, irq}, 8'h00);

    // Asynchronous reset in the middle of a burst
    push(8'hA1); push(8'hA2); push(8'hA3);
    check_val("irq_burst", {7'b0, irq}, 8'h01);
    #2;
    reset = 1'b1;
    m_fifo.delete();
    m_ovf = 1'b0;
    #1;
    check_val("irq_async_rst", {7'b0, irq}, 8'h00);
    check_val("bank_async_rst", bank, 8'h00);
    read_reg("stat_async_rst", BASE + 16'd2, exp_status());
    read_reg("head_async_rst", BASE + 16'd1, 8'h00);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    read_reg("ie_after_rst", BASE + 16'd5, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
